// File: rtl/sirv_reset_sequencer.sv
// Staged reset sequencer: waits for PLL lock (or a timeout), then releases the
// memory, peripheral and core reset domains in turn; re-sequences on SW/watchdog requests.
module sirv_reset_sequencer #(
  parameter int unsigned STAGE_DLY   = 16,
  parameter int unsigned PLL_TIMEOUT = 1024,
  parameter int unsigned SWRST_HOLD  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       test_mode,
  input  logic       io_pll_lock,
  input  logic       io_sw_rst_req,
  input  logic       io_wdog_rst,
  output logic       io_mem_reset,
  output logic       io_periph_reset,
  output logic       io_core_reset,
  output logic       io_rst_done,
  output logic [1:0] io_rst_cause,
  output logic       io_pll_timeout
);

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    WAIT_PLL   = 3'd1,
    REL_MEM    = 3'd2,
    REL_PERIPH = 3'd3,
    REL_CORE   = 3'd4,
    RUN        = 3'd5,
    SWRST      = 3'd6
  } state_t;

  localparam logic [15:0] STAGE_LAST = 16'(STAGE_DLY - 1);
  localparam logic [15:0] PLL_LAST   = 16'(PLL_TIMEOUT - 1);
  localparam logic [15:0] SWRST_LAST = 16'(SWRST_HOLD - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] cnt_r;
  logic        sync_r;
  logic        lock_s;
  logic        timeout_hit_s;

  logic        mem_r, periph_r, core_r, done_r, timeout_r;
  logic [1:0]  cause_r;
  logic        mem_s, periph_s, core_s, done_s, timeout_s;
  logic [1:0]  cause_s;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_r <= io_pll_lock;
      lock_s <= sync_r;
    end
  end

  // State register and stage counter; the counter restarts on every state change
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= HOLD;
      cnt_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s       = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      HOLD: state_s = WAIT_PLL;
      WAIT_PLL: begin
        if (lock_s) begin
          state_s = REL_MEM;
        end else if (cnt_r == PLL_LAST) begin
          state_s       = REL_MEM;
          timeout_hit_s = 1'b1;
        end else begin
          state_s = WAIT_PLL;
        end
      end
      REL_MEM: begin
        if (cnt_r == STAGE_LAST) state_s = REL_PERIPH;
        else                     state_s = REL_MEM;
      end
      REL_PERIPH: begin
        if (cnt_r == STAGE_LAST) state_s = REL_CORE;
        else                     state_s = REL_PERIPH;
      end
      REL_CORE: state_s = RUN;
      RUN: begin
        if (io_wdog_rst || io_sw_rst_req) state_s = SWRST;
        else                              state_s = RUN;
      end
      SWRST: begin
        if (cnt_r == SWRST_LAST) state_s = REL_MEM;
        else                     state_s = SWRST;
      end
      default: state_s = HOLD;
    endcase
  end

  // Output values decoded from the upcoming state so they register on the transition edge
  always_comb begin
    mem_s     = 1'b1;
    periph_s  = 1'b1;
    core_s    = 1'b1;
    done_s    = 1'b0;
    timeout_s = timeout_r | timeout_hit_s;
    case (state_s)
      REL_MEM: begin
        mem_s = 1'b0;
      end
      REL_PERIPH: begin
        mem_s    = 1'b0;
        periph_s = 1'b0;
      end
      REL_CORE, RUN: begin
        mem_s    = 1'b0;
        periph_s = 1'b0;
        core_s   = 1'b0;
        done_s   = 1'b1;
      end
      default: begin
        mem_s    = 1'b1;
        periph_s = 1'b1;
        core_s   = 1'b1;
        done_s   = 1'b0;
      end
    endcase
    if ((state_r == RUN) && (state_s == SWRST)) begin
      cause_s = io_wdog_rst ? CAUSE_WDOG : CAUSE_SW;
    end else begin
      cause_s = cause_r;
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_r     <= 1'b1;
      periph_r  <= 1'b1;
      core_r    <= 1'b1;
      done_r    <= 1'b0;
      cause_r   <= CAUSE_POR;
      timeout_r <= 1'b0;
    end else begin
      mem_r     <= mem_s;
      periph_r  <= periph_s;
      core_r    <= core_s;
      done_r    <= done_s;
      cause_r   <= cause_s;
      timeout_r <= timeout_s;
    end
  end

  // Scan bypass hands the domain resets straight to the incoming reset
  assign io_mem_reset    = test_mode ? reset  : mem_r;
  assign io_periph_reset = test_mode ? reset  : periph_r;
  assign io_core_reset   = test_mode ? reset  : core_r;
  assign io_rst_done     = test_mode ? ~reset : done_r;
  assign io_rst_cause    = cause_r;
  assign io_pll_timeout  = timeout_r;

endmodule

// File: tb/tb_sirv_reset_sequencer.sv
// Scoreboard bench: stimulus predicts output-change events (edge number + values),
// a negedge monitor pops and compares one event each time the outputs change.
module tb_sirv_reset_sequencer;
  localparam int STAGE = 16;
  localparam int PLLTO = 1024;
  localparam int HOLDC = 32;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       test_mode = 1'b0;
  logic       io_pll_lock = 1'b0;
  logic       io_sw_rst_req = 1'b0;
  logic       io_wdog_rst = 1'b0;
  logic       io_mem_reset, io_periph_reset, io_core_reset, io_rst_done;
  logic [1:0] io_rst_cause;
  logic       io_pll_timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         at;
    logic [6:0] vec;
  } ev_t;
  ev_t exp_q[$];
  ev_t cur_ev;
  logic [6:0] prev;
  logic [6:0] obs;

  sirv_reset_sequencer dut (
    .clock(clock), .reset(reset), .test_mode(test_mode), .io_pll_lock(io_pll_lock),
    .io_sw_rst_req(io_sw_rst_req), .io_wdog_rst(io_wdog_rst),
    .io_mem_reset(io_mem_reset), .io_periph_reset(io_periph_reset),
    .io_core_reset(io_core_reset), .io_rst_done(io_rst_done),
    .io_rst_cause(io_rst_cause), .io_pll_timeout(io_pll_timeout)
  );

  assign obs = {io_mem_reset, io_periph_reset, io_core_reset, io_rst_done, io_rst_cause, io_pll_timeout};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next predicted event
  always @(negedge clock) begin
    if (mon_en && (obs !== prev)) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_change edge=%0d got=%b", cyc, obs);
      end else begin
        cur_ev = exp_q.pop_front();
        if ((cur_ev.at != cyc) || (cur_ev.vec !== obs)) begin
          bad = bad + 1;
          $display("FAIL event edge=%0d got=%b want edge=%0d vec=%b", cyc, obs, cur_ev.at, cur_ev.vec);
        end
      end
    end
    prev = obs;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    total = total + 1;
    if (act !== exp_v) begin
      bad = bad + 1;
      $display("FAIL %s: got=%b want=%b", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clock);
  endtask

  task automatic push(input int at, input logic [3:0] rd, input logic [1:0] c, input logic t);
    ev_t e;
    e.at  = at;
    e.vec = {rd, c, t};
    exp_q.push_back(e);
  endtask

  // Release sequence starting with the memory domain at edge m
  task automatic push_release(input int m, input logic [1:0] c, input logic t, input int n);
    push(m, 4'b0110, c, t);
    if (n > 1) push(m + STAGE, 4'b0010, c, t);
    if (n > 2) push(m + 2 * STAGE, 4'b0001, c, t);
  endtask

  int r0, d, k, e_at, s_at, core_at, sel;
  logic [1:0] cause;
  logic rbit;

  initial begin
    // Power-on with PLL lock arriving a random number of cycles after reset
    step(3);
    chk("reset_state", obs, 7'b1110_00_0);
    mon_en = 1'b1;
    r0 = cyc;
    d = $urandom_range(0, 40);
    push_release(r0 + d + 3, 2'b00, 1'b0, 3);
    reset = 1'b0;
    step(d);
    io_pll_lock = 1'b1;
    core_at = r0 + d + 3 + 2 * STAGE;
    wait_until(core_at);

    // Random SW / watchdog requests in RUN; first one has both raised together
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(1, 6);
      step(k);
      sel = (i == 0) ? 3 : $urandom_range(1, 3);
      e_at = cyc + 1;
      cause = (sel >= 2) ? 2'b10 : 2'b01;
      push(e_at, 4'b1110, cause, 1'b0);
      push_release(e_at + HOLDC, cause, 1'b0, 3);
      io_sw_rst_req = sel[0];
      io_wdog_rst = sel[1];
      step(1);
      io_sw_rst_req = 1'b0;
      io_wdog_rst = 1'b0;
      core_at = e_at + HOLDC + 2 * STAGE;
      wait_until(core_at);
    end

    // Watchdog reset, then a SW request held from REL_MEM on is deferred until RUN
    step(1);
    e_at = cyc + 1;
    push(e_at, 4'b1110, 2'b10, 1'b0);
    push_release(e_at + HOLDC, 2'b10, 1'b0, 3);
    io_wdog_rst = 1'b1;
    step(1);
    io_wdog_rst = 1'b0;
    wait_until(e_at + HOLDC + 1);
    s_at = e_at + HOLDC + 2 * STAGE + 2;
    push(s_at, 4'b1110, 2'b01, 1'b0);
    push_release(s_at + HOLDC, 2'b01, 1'b0, 2);
    io_sw_rst_req = 1'b1;
    wait_until(s_at);
    io_sw_rst_req = 1'b0;

    // Reset raised in REL_PERIPH, then a full restart
    wait_until(s_at + HOLDC + STAGE + 3);
    push(cyc + 1, 4'b1110, 2'b00, 1'b0);
    reset = 1'b1;
    step(2);
    r0 = cyc;
    push_release(r0 + 3, 2'b00, 1'b0, 3);
    reset = 1'b0;
    wait_until(r0 + 3 + 2 * STAGE);

    // Lock reaching the FSM exactly on the last timeout cycle wins over the timeout
    step(1);
    push(cyc + 1, 4'b1110, 2'b00, 1'b0);
    reset = 1'b1;
    io_pll_lock = 1'b0;
    step(2);
    r0 = cyc;
    push_release(r0 + PLLTO + 1, 2'b00, 1'b0, 3);
    reset = 1'b0;
    wait_until(r0 + PLLTO - 2);
    io_pll_lock = 1'b1;
    wait_until(r0 + PLLTO + 1 + 2 * STAGE);

    // No lock at all: timeout flag sets with the memory release and stays set
    step(1);
    push(cyc + 1, 4'b1110, 2'b00, 1'b0);
    reset = 1'b1;
    io_pll_lock = 1'b0;
    step(2);
    r0 = cyc;
    push_release(r0 + PLLTO + 1, 2'b00, 1'b1, 3);
    reset = 1'b0;
    wait_until(r0 + PLLTO + 1);
    io_pll_lock = 1'b1;
    wait_until(r0 + PLLTO + 1 + 2 * STAGE);
    step(5);

    // Test mode: domain resets follow reset combinationally regardless of FSM state
    mon_en = 1'b0;
    test_mode = 1'b1;
    #1;
    chk("tm_run_low", {3'b000, obs[6:3]}, 7'b000_0001);
    reset = 1'b1;
    #1;
    chk("tm_reset_high", {3'b000, obs[6:3]}, 7'b000_1110);
    step(1);
    io_pll_lock = 1'b0;
    reset = 1'b0;
    #1;
    chk("tm_hold_low", {3'b000, obs[6:3]}, 7'b000_0001);
    for (int i = 0; i < 6; i++) begin
      step(1);
      rbit = 1'($urandom_range(0, 1));
      reset = rbit;
      #1;
      chk("tm_track", {3'b000, obs[6:3]}, {3'b000, rbit, rbit, rbit, ~rbit});
    end
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    #1;
    chk("tm_after_reset", {3'b000, obs[6:3]}, 7'b000_0001);
    io_pll_lock = 1'b1;
    step(40);
    test_mode = 1'b0;
    #1;
    chk("tm_exit_run", obs, 7'b0001_00_0);

    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_events: got=%0d pending want=0 (next edge=%0d)", exp_q.size(), exp_q[0].at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
